enemy_missile_ctl: RTL and testbench
====================================

Name: enemy_missile_ctl

Overview:
Generates up to three enemy missiles and moves them down the screen. It launches missiles from the living enemies of the formation and feeds the en_x_missile1..3 / en_y_missile1..3 inputs of the ship stage, which uses them for collision detection. It also produces per-missile "on" flags for the enemy-missile draw stage.

Parameters:
SCREEN_H, 768, visible height in px; a missile is retired when it reaches this row.
ENEMY_W, 32, enemy sprite width in px; the missile is launched at the horizontal centre (ENEMY_W/2).
ENEMY_H, 32, enemy sprite height in px; the launch y is enemy_y + ENEMY_H.
COL_SPACING, 64, horizontal pitch between the formation's 4 enemy columns, in px.
STEP, 4, px moved per move tick.
MOVE_DIV, 650000, pclk cycles per move tick (100 Hz at 65 MHz).
LAUNCH_PERIOD, 40, number of move ticks between launch attempts.

Ports:
pclk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
enemy_x  in  11  x of column-0 enemy (formation origin)
enemy_y  in  11  y of formation top
alive_mask  in  4  bit i = enemy column i alive
freeze  in  1  ship dead / game halted; blocks new launches
en_x_missile1..3  out  11 each  missile x; 0 when inactive
en_y_missile1..3  out  11 each  missile y; 0 when inactive
en_on1..3  out  1 each  missile active

Behaviour:
- All outputs are registered.
- Reset (rst==0 at a clock edge):
  - All x, y and on outputs = 0.
  - move_cnt = 0, launch_cnt = 0, LFSR = 8'hA5.
  - Reset applied mid-flight clears all missiles on the next edge.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances every cycle when out of reset and never reaches 0.
- Move tick:
  - move_cnt counts 0..MOVE_DIV-1 and wraps.
  - The tick is a 1-cycle pulse in the cycle where move_cnt == MOVE_DIV-1.
  - With MOVE_DIV=1, the tick fires every cycle.
- Per-slot FSM, slot k in {1,2,3}, states IDLE and FLY:
  - IDLE→FLY on a launch into slot k. On that edge: y = enemy_y + ENEMY_H; x = enemy_x + col*COL_SPACING + ENEMY_W/2 (11-bit, wrap ignored); on = 1.
  - FLY on a tick: if y + STEP >= SCREEN_H (12-bit compare), go to IDLE on the same edge with x = y = on = 0. Otherwise y = y + STEP and x is held.
  - A missile launched on a tick does not move on that tick.
- Launch scheduler:
  - On each tick, launch_cnt increments. At LAUNCH_PERIOD-1 it wraps to 0 and a launch attempt is made in the same cycle.
  - Attempt fails (no launch, counter still wraps) if freeze==1, alive_mask==0, or no slot is IDLE.
  - Slot choice: the lowest-index slot that is IDLE before this tick's updates. A slot retired on the same tick is not reusable until the next attempt.
  - Column choice: start at c = LFSR[1:0]. If alive_mask[c]==0, take the next alive column upward, wrapping 3→0.
  - Inputs are sampled in the attempt cycle.
- freeze only blocks launches. Missiles in flight keep falling and retire normally.
- Exactly one launch per attempt maximum.

Test Plan:
Use MOVE_DIV=4, LAUNCH_PERIOD=2, SCREEN_H=100, STEP=4, ENEMY_H=32, ENEMY_W=32, COL_SPACING=64 unless stated otherwise.
1. Reset: hold rst=0 for 5 cycles → all outputs 0. Release → first tick at cycle 4 after release, first launch attempt on the 2nd tick (cycle 8).
2. Forced column: alive_mask=4'b0100, enemy_x=100, enemy_y=10 → slot1 launches with x=100+128+16=244, y=42, en_on1=1; y=46 on the next tick.
3. Retire boundary: slot1 reaches y=94 → next tick 94+4=98<100 gives y=98. The tick after, 98+4≥100 → x=y=en_on1=0.
4. Slot allocation: mask=4'b1111, freeze=0, run 3 attempts → slots 1,2,3 become active in order. The 4th attempt with all slots busy → no change. When slot1 retires on an attempt tick, it is refilled only at the following attempt.
5. Freeze: slots active, freeze=1 → no new en_on rising edges over 10 attempts; existing missiles still advance 4 px per tick and retire. alive_mask=0 gives the same no-launch result.
6. Mid-flight reset: rst=0 for 1 cycle while 3 missiles fly → all outputs 0 on that edge. LFSR reseeds to 8'hA5 and the launch sequence after reset repeats identically.

Source files
------------

// File: rtl/enemy_missile_ctl.sv
//------------------------------------------------------------------------------
// Module   : enemy_missile_ctl
// Brief    : Launches up to three enemy missiles from living formation columns
//            and moves them down the screen on a divided move tick.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module enemy_missile_ctl #(
    parameter int SCREEN_H      = 768,
    parameter int ENEMY_W       = 32,
    parameter int ENEMY_H       = 32,
    parameter int COL_SPACING   = 64,
    parameter int STEP          = 4,
    parameter int MOVE_DIV      = 650000,
    parameter int LAUNCH_PERIOD = 40
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] enemy_x,
    input  logic [10:0] enemy_y,
    input  logic [3:0]  alive_mask,
    input  logic        freeze,
    output logic [10:0] en_x_missile1,
    output logic [10:0] en_x_missile2,
    output logic [10:0] en_x_missile3,
    output logic [10:0] en_y_missile1,
    output logic [10:0] en_y_missile2,
    output logic [10:0] en_y_missile3,
    output logic        en_on1,
    output logic        en_on2,
    output logic        en_on3
);

    localparam int MOVE_W   = (MOVE_DIV > 1)      ? $clog2(MOVE_DIV)      : 1;
    localparam int LAUNCH_W = (LAUNCH_PERIOD > 1) ? $clog2(LAUNCH_PERIOD) : 1;

    localparam logic [MOVE_W-1:0]   c_MOVE_LAST   = MOVE_W'(MOVE_DIV - 1);
    localparam logic [LAUNCH_W-1:0] c_LAUNCH_LAST = LAUNCH_W'(LAUNCH_PERIOD - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_FLY  = 1'b1;

    logic [MOVE_W-1:0]   move_cnt_q,   move_cnt_d;
    logic [LAUNCH_W-1:0] launch_cnt_q, launch_cnt_d;
    logic [7:0]          lfsr_q,       lfsr_d;

    logic [0:0]  state_q [3];
    logic [0:0]  state_d [3];
    logic [10:0] x_q     [3];
    logic [10:0] x_d     [3];
    logic [10:0] y_q     [3];
    logic [10:0] y_d     [3];

    logic        w_tick;
    logic        w_attempt;
    logic        w_launch;
    logic [1:0]  w_col;
    logic [2:0]  w_free;
    logic [2:0]  w_pick;
    logic [10:0] w_launch_x;
    logic [10:0] w_launch_y;

    assign w_tick    = (move_cnt_q == c_MOVE_LAST);
    assign w_attempt = w_tick && (launch_cnt_q == c_LAUNCH_LAST);

    assign move_cnt_d   = w_tick ? '0 : move_cnt_q + MOVE_W'(1);
    assign launch_cnt_d = !w_tick   ? launch_cnt_q :
                          w_attempt ? '0 : launch_cnt_q + LAUNCH_W'(1);

    // Taps 8,6,5,4 shifted in at bit 0; the all-zero state is unreachable from A5.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    assign w_free = {state_q[2] == c_IDLE, state_q[1] == c_IDLE, state_q[0] == c_IDLE};

    always_comb begin
        w_pick = 3'b000;
        if (w_free[0])      w_pick = 3'b001;
        else if (w_free[1]) w_pick = 3'b010;
        else if (w_free[2]) w_pick = 3'b100;
    end

    // Scanning offsets high to low leaves the nearest alive column at or above the seed.
    always_comb begin
        w_col = lfsr_q[1:0];
        for (int i = 3; i >= 0; i--) begin
            if (alive_mask[lfsr_q[1:0] + 2'(i)]) w_col = lfsr_q[1:0] + 2'(i);
        end
    end

    assign w_launch   = w_attempt && !freeze && (|alive_mask) && (|w_free);
    assign w_launch_x = enemy_x + 11'(32'(w_col) * COL_SPACING) + 11'(ENEMY_W / 2);
    assign w_launch_y = enemy_y + 11'(ENEMY_H);

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            state_d[k] = state_q[k];
            x_d[k]     = x_q[k];
            y_d[k]     = y_q[k];
            if (w_launch && w_pick[k]) begin
                state_d[k] = c_FLY;
                x_d[k]     = w_launch_x;
                y_d[k]     = w_launch_y;
            end else if (w_tick && (state_q[k] == c_FLY)) begin
                if (({1'b0, y_q[k]} + 12'(STEP)) >= 12'(SCREEN_H)) begin
                    state_d[k] = c_IDLE;
                    x_d[k]     = '0;
                    y_d[k]     = '0;
                end else begin
                    y_d[k] = y_q[k] + 11'(STEP);
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            move_cnt_q   <= '0;
            launch_cnt_q <= '0;
            lfsr_q       <= 8'hA5;
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= c_IDLE;
                x_q[k]     <= '0;
                y_q[k]     <= '0;
            end
        end else begin
            move_cnt_q   <= move_cnt_d;
            launch_cnt_q <= launch_cnt_d;
            lfsr_q       <= lfsr_d;
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= state_d[k];
                x_q[k]     <= x_d[k];
                y_q[k]     <= y_d[k];
            end
        end
    end

    assign en_x_missile1 = x_q[0];
    assign en_x_missile2 = x_q[1];
    assign en_x_missile3 = x_q[2];
    assign en_y_missile1 = y_q[0];
    assign en_y_missile2 = y_q[1];
    assign en_y_missile3 = y_q[2];
    assign en_on1        = (state_q[0] == c_FLY);
    assign en_on2        = (state_q[1] == c_FLY);
    assign en_on3        = (state_q[2] == c_FLY);

endmodule

`default_nettype wire

// File: tb/tb_enemy_missile_ctl.sv
//------------------------------------------------------------------------------
// Module   : tb_enemy_missile_ctl
// Brief    : Directed self-checking bench for enemy_missile_ctl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_enemy_missile_ctl;

    logic        pclk = 1'b0;
    logic        rst  = 1'b0;
    logic [10:0] enemy_x;
    logic [10:0] enemy_y;
    logic [3:0]  alive_mask;
    logic        freeze;
    logic [10:0] x1, x2, x3, y1, y2, y3;
    logic        on1, on2, on3;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    enemy_missile_ctl #(
        .SCREEN_H      (100),
        .ENEMY_W       (32),
        .ENEMY_H       (32),
        .COL_SPACING   (64),
        .STEP          (4),
        .MOVE_DIV      (4),
        .LAUNCH_PERIOD (2)
    ) dut (
        .pclk          (pclk),
        .rst           (rst),
        .enemy_x       (enemy_x),
        .enemy_y       (enemy_y),
        .alive_mask    (alive_mask),
        .freeze        (freeze),
        .en_x_missile1 (x1),
        .en_x_missile2 (x2),
        .en_x_missile3 (x3),
        .en_y_missile1 (y1),
        .en_y_missile2 (y2),
        .en_y_missile3 (y3),
        .en_on1        (on1),
        .en_on2        (on2),
        .en_on3        (on3)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge pclk);
            cyc++;
        end
        #1;
    endtask

    task automatic wait_to(input int e);
        if (e > cyc) clk_n(e - cyc);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        clk_n(1);
        rst = 1'b1;
        cyc = 0;
    endtask

    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    // Launch x for an attempt resolved at edge e (seed seen during that cycle).
    function automatic logic [10:0] launch_x(input int e, input logic [3:0] m);
        logic [7:0] v;
        logic [1:0] c;
        v = lfsr_after(e - 1);
        c = v[1:0];
        if (!m[c]) begin
            if (m[c + 2'd1])      c = c + 2'd1;
            else if (m[c + 2'd2]) c = c + 2'd2;
            else                  c = c + 2'd3;
        end
        return 11'(100 + 64 * int'(c) + 16);
    endfunction

    logic [2:0] prev_on;
    logic       rose;

    initial begin
        enemy_x    = 11'd100;
        enemy_y    = 11'd10;
        alive_mask = 4'b0100;
        freeze     = 1'b0;

        // Reset held for five edges
        rst = 1'b0;
        clk_n(5);
        chk("rst_on",  {29'd0, on3, on2, on1}, 32'd0);
        chk("rst_x",   {21'd0, x1 | x2 | x3}, 32'd0);
        chk("rst_y",   {21'd0, y1 | y2 | y3}, 32'd0);
        rst = 1'b1;
        cyc = 0;

        // First attempt on the second tick, forced column 2
        wait_to(7);
        chk("pre_attempt_on1", {31'd0, on1}, 32'd0);
        wait_to(8);
        chk("launch_on1", {31'd0, on1}, 32'd1);
        chk("launch_x1",  {21'd0, x1}, 32'd244);
        chk("launch_y1",  {21'd0, y1}, 32'd42);
        chk("launch_on2", {31'd0, on2}, 32'd0);
        wait_to(11);
        chk("hold_y1", {21'd0, y1}, 32'd42);
        wait_to(12);
        chk("move_y1", {21'd0, y1}, 32'd46);
        wait_to(16);
        chk("slot2_on", {31'd0, on2}, 32'd1);
        chk("slot2_x",  {21'd0, x2}, 32'd244);
        chk("slot2_y",  {21'd0, y2}, 32'd42);
        chk("slot1_y50", {21'd0, y1}, 32'd50);

        // Retire boundary
        wait_to(60);
        chk("y1_94", {21'd0, y1}, 32'd94);
        wait_to(64);
        chk("y1_98",  {21'd0, y1}, 32'd98);
        chk("on1_98", {31'd0, on1}, 32'd1);
        wait_to(68);
        chk("retire_on1", {31'd0, on1}, 32'd0);
        chk("retire_x1",  {21'd0, x1}, 32'd0);
        chk("retire_y1",  {21'd0, y1}, 32'd0);
        chk("slot2_y94",  {21'd0, y2}, 32'd94);
        wait_to(72);
        chk("refill_on1", {31'd0, on1}, 32'd1);
        chk("refill_y1",  {21'd0, y1}, 32'd42);

        // Slot allocation with all columns alive, retire on an attempt tick
        enemy_y    = 11'd12;
        alive_mask = 4'b1111;
        pulse_reset();
        wait_to(8);
        chk("alloc1_on", {29'd0, on3, on2, on1}, 32'b001);
        chk("alloc1_x",  {21'd0, x1}, 32'd308);
        chk("alloc1_y",  {21'd0, y1}, 32'd44);
        wait_to(16);
        chk("alloc2_on", {29'd0, on3, on2, on1}, 32'b011);
        chk("alloc2_x",  {21'd0, x2}, {21'd0, launch_x(16, 4'b1111)});
        wait_to(24);
        chk("alloc3_on", {29'd0, on3, on2, on1}, 32'b111);
        chk("alloc3_x",  {21'd0, x3}, {21'd0, launch_x(24, 4'b1111)});
        wait_to(32);
        chk("busy_on", {29'd0, on3, on2, on1}, 32'b111);
        chk("busy_x1", {21'd0, x1}, 32'd308);
        chk("busy_y1", {21'd0, y1}, 32'd68);
        wait_to(60);
        chk("alloc_y1_96", {21'd0, y1}, 32'd96);
        wait_to(64);
        chk("retire_attempt_on", {29'd0, on3, on2, on1}, 32'b110);
        chk("retire_attempt_y1", {21'd0, y1}, 32'd0);
        wait_to(72);
        chk("reuse_on", {29'd0, on3, on2, on1}, 32'b101);
        chk("reuse_x1", {21'd0, x1}, {21'd0, launch_x(72, 4'b1111)});
        chk("reuse_y1", {21'd0, y1}, 32'd44);

        // Freeze blocks launches while missiles keep falling
        enemy_y    = 11'd10;
        alive_mask = 4'b0100;
        pulse_reset();
        wait_to(8);
        chk("frz_launch_on1", {31'd0, on1}, 32'd1);
        freeze  = 1'b1;
        prev_on = {on3, on2, on1};
        rose    = 1'b0;
        for (int e = 9; e <= 88; e++) begin
            clk_n(1);
            if (({on3, on2, on1} & ~prev_on) != 3'b000) rose = 1'b1;
            prev_on = {on3, on2, on1};
            if (cyc == 16) chk("frz_y1_50", {21'd0, y1}, 32'd50);
            if (cyc == 68) chk("frz_retire_on1", {31'd0, on1}, 32'd0);
        end
        chk("frz_no_rise", {31'd0, rose}, 32'd0);
        freeze     = 1'b0;
        alive_mask = 4'b0000;
        wait_to(104);
        chk("mask0_on", {29'd0, on3, on2, on1}, 32'd0);
        alive_mask = 4'b0100;
        wait_to(112);
        chk("unfrz_on1", {31'd0, on1}, 32'd1);
        chk("unfrz_y1",  {21'd0, y1}, 32'd42);

        // Mid-flight reset and repeatable launch sequence
        alive_mask = 4'b1111;
        pulse_reset();
        wait_to(24);
        chk("mid_pre_on", {29'd0, on3, on2, on1}, 32'b111);
        rst = 1'b0;
        clk_n(1);
        chk("mid_rst_on", {29'd0, on3, on2, on1}, 32'd0);
        chk("mid_rst_x",  {21'd0, x1 | x2 | x3}, 32'd0);
        chk("mid_rst_y",  {21'd0, y1 | y2 | y3}, 32'd0);
        rst = 1'b1;
        cyc = 0;
        wait_to(8);
        chk("rep_x1", {21'd0, x1}, 32'd308);
        chk("rep_y1", {21'd0, y1}, 32'd42);
        wait_to(16);
        chk("rep_x2", {21'd0, x2}, {21'd0, launch_x(16, 4'b1111)});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
